// File: rtl/vga_bounce_engine.sv
// vga_bounce_engine: VGA timing generator that draws a one-pixel border and up
// to eight bouncing filled discs, each in its own palette colour.
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   en                discs move on the per-frame update strobe when high
//   VGA_R/G/B [CW]    pixel colour (top CW bits of each 8-bit palette channel)
//   VGA_HS, VGA_VS    syncs, active level HS_POL / VS_POL
//   VGA_DE            active-video flag
//   frame_start       one-cycle pulse with output pixel (0,0)
// All outputs are two cycles behind the counter value that produced them.
module vga_bounce_engine #(
  parameter int unsigned HWIDTH  = 640,
  parameter int unsigned HFPORCH = 16,
  parameter int unsigned HSYNC   = 96,
  parameter int unsigned HBPORCH = 48,
  parameter int unsigned VWIDTH  = 480,
  parameter int unsigned VFPORCH = 11,
  parameter int unsigned VSYNC   = 2,
  parameter int unsigned VBPORCH = 31,
  parameter bit          HS_POL  = 1'b0,
  parameter bit          VS_POL  = 1'b0,
  parameter int unsigned NBALLS  = 4,
  parameter int unsigned RADIUS  = 30,
  parameter int unsigned STEP    = 5,
  parameter int unsigned CW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] VGA_R,
  output logic [CW-1:0] VGA_G,
  output logic [CW-1:0] VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE,
  output logic          frame_start
);

  localparam int unsigned HTOTAL   = HWIDTH + HFPORCH + HSYNC + HBPORCH;
  localparam int unsigned VTOTAL   = VWIDTH + VFPORCH + VSYNC + VBPORCH;
  localparam int unsigned HCW      = $clog2(HTOTAL);
  localparam int unsigned VCW      = $clog2(VTOTAL);
  localparam int unsigned XW       = HCW + 2;
  localparam int unsigned SQW      = 2 * XW;
  localparam int unsigned SUMW     = SQW + 1;
  localparam int unsigned HS_BEG   = HWIDTH + HFPORCH;
  localparam int unsigned HS_END   = HS_BEG + HSYNC;
  localparam int unsigned VS_BEG   = VWIDTH + VFPORCH;
  localparam int unsigned VS_END   = VS_BEG + VSYNC;
  localparam int unsigned UPD_LINE = VWIDTH + VFPORCH;
  localparam int unsigned R2       = RADIUS * RADIUS;

  localparam logic signed [XW-1:0] S_STEP = XW'(STEP);
  localparam logic signed [XW-1:0] S_RAD  = XW'(RADIUS);
  localparam logic signed [XW-1:0] X_LIM  = XW'(HWIDTH - 1);
  localparam logic signed [XW-1:0] X_HI   = XW'(HWIDTH - 1 - RADIUS);
  localparam logic signed [XW-1:0] Y_LIM  = XW'(VWIDTH - 1);
  localparam logic signed [XW-1:0] Y_HI   = XW'(VWIDTH - 1 - RADIUS);
  localparam logic [23:0]          BORDER_RGB = 24'h0050FF;

  // Parameter sanity: discs must fit between the walls with room to step.
  if (HWIDTH <= 2 * (RADIUS + STEP) + 1) begin : g_bad_hwidth
    $error("vga_bounce_engine: HWIDTH too small for RADIUS and STEP");
  end
  if (VWIDTH <= 2 * (RADIUS + STEP) + 1) begin : g_bad_vwidth
    $error("vga_bounce_engine: VWIDTH too small for RADIUS and STEP");
  end
  if (NBALLS < 1 || NBALLS > 8) begin : g_bad_nballs
    $error("vga_bounce_engine: NBALLS must be 1..8");
  end

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'h00FF00;
      3'd1:    return 24'hFF0000;
      3'd2:    return 24'hFFFF00;
      3'd3:    return 24'hFF00FF;
      3'd4:    return 24'h00FFFF;
      3'd5:    return 24'hFF8000;
      3'd6:    return 24'hFFFFFF;
      default: return 24'h8080FF;
    endcase
  endfunction

  // Discs start spread diagonally across the visible area.
  function automatic logic signed [XW-1:0] init_pos(input int unsigned span,
                                                    input int unsigned idx);
    return XW'(RADIUS + ((span - 2 * RADIUS - 1) * idx) / NBALLS);
  endfunction

  // Sign-extend before squaring so the product is exact.
  function automatic logic [SQW-1:0] sq(input logic signed [XW-1:0] d);
    logic signed [SQW-1:0] de;
    de = SQW'(d);
    return de * de;
  endfunction

  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;
  logic           strobe;

  // Raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HCW'(HTOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VCW'(VTOTAL - 1)) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Once per frame, in vertical blanking.
  assign strobe = (hcnt == '0) && (vcnt == VCW'(UPD_LINE));

  logic signed [XW-1:0] x_q   [NBALLS];
  logic signed [XW-1:0] y_q   [NBALLS];
  logic                 dir_x [NBALLS];
  logic                 dir_y [NBALLS];

  // Disc positions; dir 0 = increasing, reflect when the next step hits a wall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NBALLS); i++) begin
        x_q[i]   <= init_pos(HWIDTH, unsigned'(i));
        y_q[i]   <= init_pos(VWIDTH, unsigned'(i));
        dir_x[i] <= 1'(i % 2);
        dir_y[i] <= 1'b0;
      end
    end else if (strobe && en) begin
      for (int i = 0; i < int'(NBALLS); i++) begin
        if (!dir_x[i]) begin
          if (x_q[i] + S_STEP + S_RAD >= X_LIM) begin
            x_q[i]   <= X_HI;
            dir_x[i] <= 1'b1;
          end else begin
            x_q[i] <= x_q[i] + S_STEP;
          end
        end else if (x_q[i] - S_STEP <= S_RAD) begin
          x_q[i]   <= S_RAD;
          dir_x[i] <= 1'b0;
        end else begin
          x_q[i] <= x_q[i] - S_STEP;
        end

        if (!dir_y[i]) begin
          if (y_q[i] + S_STEP + S_RAD >= Y_LIM) begin
            y_q[i]   <= Y_HI;
            dir_y[i] <= 1'b1;
          end else begin
            y_q[i] <= y_q[i] + S_STEP;
          end
        end else if (y_q[i] - S_STEP <= S_RAD) begin
          y_q[i]   <= S_RAD;
          dir_y[i] <= 1'b0;
        end else begin
          y_q[i] <= y_q[i] - S_STEP;
        end
      end
    end
  end

  logic signed [XW-1:0] hpos;
  logic signed [XW-1:0] vpos;
  assign hpos = XW'(hcnt);
  assign vpos = XW'(vcnt);

  logic [HCW-1:0] s1_h;
  logic [VCW-1:0] s1_v;
  logic           s1_vld;
  logic [SQW-1:0] dx2_q [NBALLS];
  logic [SQW-1:0] dy2_q [NBALLS];

  // Stage 1: counter copy and per-disc squared distances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_h   <= '0;
      s1_v   <= '0;
      s1_vld <= 1'b0;
      for (int i = 0; i < int'(NBALLS); i++) begin
        dx2_q[i] <= '0;
        dy2_q[i] <= '0;
      end
    end else begin
      s1_h   <= hcnt;
      s1_v   <= vcnt;
      s1_vld <= 1'b1;
      for (int i = 0; i < int'(NBALLS); i++) begin
        dx2_q[i] <= sq(hpos - x_q[i]);
        dy2_q[i] <= sq(vpos - y_q[i]);
      end
    end
  end

  logic        hit;
  logic [23:0] disc_rgb;
  logic [23:0] pix;
  logic        de_on;
  logic        border;
  logic        hs_on;
  logic        vs_on;
  logic        fs_on;

  // Stage 2 decode; descending scan so the lowest covering disc wins.
  always_comb begin
    hit      = 1'b0;
    disc_rgb = '0;
    pix      = '0;
    for (int i = int'(NBALLS) - 1; i >= 0; i--) begin
      if (SUMW'(dx2_q[i]) + SUMW'(dy2_q[i]) <= SUMW'(R2)) begin
        hit      = 1'b1;
        disc_rgb = palette(3'(i));
      end
    end
    de_on  = s1_vld && (32'(s1_h) < HWIDTH) && (32'(s1_v) < VWIDTH);
    border = (s1_h == '0) || (32'(s1_h) == HWIDTH - 1) ||
             (s1_v == '0) || (32'(s1_v) == VWIDTH - 1);
    hs_on  = s1_vld && (32'(s1_h) >= HS_BEG) && (32'(s1_h) < HS_END);
    vs_on  = s1_vld && (32'(s1_v) >= VS_BEG) && (32'(s1_v) < VS_END);
    fs_on  = s1_vld && (s1_h == '0) && (s1_v == '0);
    if (de_on) begin
      if (border) begin
        pix = BORDER_RGB;
      end else if (hit) begin
        pix = disc_rgb;
      end
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_DE      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      VGA_R       <= pix[23 -: CW];
      VGA_G       <= pix[15 -: CW];
      VGA_B       <= pix[7 -: CW];
      VGA_HS      <= hs_on ? HS_POL : ~HS_POL;
      VGA_VS      <= vs_on ? VS_POL : ~VS_POL;
      VGA_DE      <= de_on;
      frame_start <= fs_on;
    end
  end

endmodule

// File: tb/tb_vga_bounce_engine.sv
// Scoreboard bench for vga_bounce_engine: a behavioural raster/disc model
// pushes the expected output for every counter value; a negedge monitor pops
// one entry per cycle and compares, plus per-frame sync/DE totals and a few
// hand-derived pixels in the first frame after each reset.
module tb_vga_bounce_engine;

  localparam int HW = 32, HFP = 2, HSY = 4, HBP = 2;
  localparam int VW = 24, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HW + HFP + HSY + HBP;
  localparam int VT = VW + VFP + VSY + VBP;
  localparam int RAD = 3, STP = 2, CW = 4, NB = 8;
  localparam int NFRAMES = 36;
  localparam int RST_FRAME = 20;
  localparam logic [15:0] RST_VEC = 16'h000C;
  localparam logic [23:0] PAL [8] = '{24'h00FF00, 24'hFF0000, 24'hFFFF00,
    24'hFF00FF, 24'h00FFFF, 24'hFF8000, 24'hFFFFFF, 24'h8080FF};

  logic          clk, rst_n, en;
  logic [CW-1:0] VGA_R, VGA_G, VGA_B;
  logic          VGA_HS, VGA_VS, VGA_DE, frame_start;
  logic [15:0]   dut_vec;

  vga_bounce_engine #(
    .HWIDTH(HW), .HFPORCH(HFP), .HSYNC(HSY), .HBPORCH(HBP),
    .VWIDTH(VW), .VFPORCH(VFP), .VSYNC(VSY), .VBPORCH(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .NBALLS(NB), .RADIUS(RAD), .STEP(STP), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
    .frame_start(frame_start)
  );

  assign dut_vec = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, frame_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] rgb;
    logic        hs, vs, de, fs;
    int          h, v;
    bit          first;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: raster position and disc positions/directions.
  int mh, mv, mframe;
  int mx[NB], my[NB];
  bit mdx[NB], mdy[NB];

  function automatic void model_reset();
    mh = 0; mv = 0; mframe = 0;
    for (int i = 0; i < NB; i++) begin
      mx[i]  = RAD + ((HW - 2 * RAD - 1) * i) / NB;
      my[i]  = RAD + ((VW - 2 * RAD - 1) * i) / NB;
      mdx[i] = bit'(i % 2);
      mdy[i] = 1'b0;
    end
  endfunction

  task automatic axis(input int p, input bit d, input int w, output int np, output bit nd);
    np = p; nd = d;
    if (!d) begin
      if (p + STP + RAD >= w - 1) begin np = w - 1 - RAD; nd = 1'b1; end
      else np = p + STP;
    end else begin
      if (p - STP <= RAD) begin np = RAD; nd = 1'b0; end
      else np = p - STP;
    end
  endtask

  function automatic exp_t predict(input int h, input int v, input bit first);
    exp_t e;
    logic [23:0] c;
    bit found;
    e.h = h; e.v = v; e.first = first;
    e.de = (h < HW) && (v < VW);
    e.hs = (h >= HW + HFP && h < HW + HFP + HSY) ? 1'b0 : 1'b1;
    e.vs = (v >= VW + VFP && v < VW + VFP + VSY) ? 1'b0 : 1'b1;
    e.fs = (h == 0) && (v == 0);
    c = 24'h0; found = 1'b0;
    if (e.de) begin
      if (h == 0 || h == HW - 1 || v == 0 || v == VW - 1) c = 24'h0050FF;
      else
        for (int i = 0; i < NB; i++)
          if (!found && (h - mx[i]) * (h - mx[i]) + (v - my[i]) * (v - my[i]) <= RAD * RAD) begin
            found = 1'b1;
            c = PAL[i];
          end
    end
    e.rgb = {c[23:20], c[15:12], c[7:4]};
    return e;
  endfunction

  function automatic exp_t reset_entry();
    exp_t e;
    e.rgb = 12'h0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.fs = 1'b0;
    e.h = -1; e.v = -1; e.first = 1'b0;
    return e;
  endfunction

  // Model: one expectation per counter value; output lags it by two cycles,
  // so reset leaves two reset-valued entries ahead of pixel (0,0).
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      sb.delete();
      sb.push_back(reset_entry());
      sb.push_back(reset_entry());
      model_reset();
    end else begin
      sb.push_back(predict(mh, mv, mframe == 0));
      if (mh == 0 && mv == VW + VFP && en) begin
        for (int i = 0; i < NB; i++) begin
          int np; bit nd;
          axis(mx[i], mdx[i], HW, np, nd); mx[i] = np; mdx[i] = nd;
          axis(my[i], mdy[i], VW, np, nd); my[i] = np; mdy[i] = nd;
        end
      end
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin mv = 0; mframe++; end
        else mv++;
      end else mh++;
    end
  end

  // Monitor.
  bit have_prev = 1'b0;
  int cyc, de_n, hs_n, vs_n;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {16'h0, dut_vec}, {16'h0, RST_VEC});
      have_prev = 1'b0;
    end else if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("pixel h=%0d v=%0d", e.h, e.v), {16'h0, dut_vec},
            {16'h0, e.rgb, e.hs, e.vs, e.de, e.fs});
      if (e.first) begin
        if (e.h == 3 && e.v == 6) check("disc_edge_in", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h0F0);
        if (e.h == 3 && e.v == 7) check("disc_edge_out", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h000);
        if (e.h == 0 && e.v == 3) check("border_left", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h05F);
        if (e.h == 4 && e.v == 4) check("overlap_prio", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h0F0);
        if (e.h == 35 && e.v == 5) check("hblank_black", {19'h0, VGA_R, VGA_G, VGA_B, VGA_DE}, 32'h0);
      end
      if (frame_start) begin
        if (have_prev) begin
          check("frame_period", cyc, HT * VT);
          check("de_per_frame", de_n, HW * VW);
          check("hs_low_per_frame", hs_n, HSY * VT);
          check("vs_low_per_frame", vs_n, VSY * HT);
        end
        have_prev = 1'b1;
        cyc = 0; de_n = 0; hs_n = 0; vs_n = 0;
      end
      cyc++;
      de_n += int'(VGA_DE);
      hs_n += int'(!VGA_HS);
      vs_n += int'(!VGA_VS);
    end
  end

  // Stimulus: random en per frame, a forced 3-frame en=0 stretch, one mid-line reset.
  initial begin
    int flip_at, rst_at;
    bit nen;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1; en = 1'b1;
    for (int f = 0; f < NFRAMES; f++) begin
      flip_at = int'($urandom_range(0, HT * VT - 1));
      rst_at  = int'($urandom_range(100, 1000));
      if (f >= 14 && f < 17) nen = 1'b0;
      else if (f == 17) nen = 1'b1;
      else nen = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < HT * VT; c++) begin
        @(posedge clk);
        #2;
        if (c == flip_at) en = nen;
        if (f == RST_FRAME && c == rst_at) begin
          rst_n = 1'b0;
          #1 check("reset_async", {16'h0, dut_vec}, {16'h0, RST_VEC});
          repeat (3) @(posedge clk);
          #2 rst_n = 1'b1;
        end
      end
    end
    @(negedge clk);
    #1 check("scoreboard_depth", sb.size(), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_bounce_engine.md
# vga_bounce_engine

Parametrised VGA test-pattern generator for the VirtualDevBoard demos. It produces VGA timing with configurable sync polarity and renders a one-pixel border plus up to 8 independently bouncing filled discs, each in its own colour. The output stage is pipelined and sync-aligned, and drives the board VGA pins directly.

## Interface
- HWIDTH, 640, visible pixels per line
- HFPORCH / HSYNC / HBPORCH, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- VWIDTH, 480, visible lines
- VFPORCH / VSYNC / VBPORCH, 11 / 2 / 31, vertical front porch / sync / back porch (lines)
- HS_POL / VS_POL, 0 / 0, active level of HS / VS
- NBALLS, 4, number of discs, 1..8
- RADIUS, 30, disc radius in pixels
- STEP, 5, pixels moved per axis per frame
- CW, 4, bits per colour channel, 1..8
- rst_n, input, 1, asynchronous active-low reset
- clk, input, 1, pixel clock
- en, input, 1, 1 = discs move; 0 = positions and directions frozen
- VGA_R / VGA_G / VGA_B, output, CW each, pixel colour
- VGA_HS / VGA_VS, output, 1 each, sync outputs
- VGA_DE, output, 1, active-video flag
- frame_start, output, 1, one-cycle pulse coincident with output pixel (0,0)

## Operation
- Counters: hcnt 0..HTOTAL-1 and vcnt 0..VTOTAL-1, where HTOTAL and VTOTAL are the sums of the four horizontal and four vertical parameters. vcnt increments when hcnt wraps; vcnt wraps to 0 after VTOTAL-1.
- HS is active for hcnt in [HWIDTH+HFPORCH, HWIDTH+HFPORCH+HSYNC). VS is active for vcnt in [VWIDTH+VFPORCH, VWIDTH+VFPORCH+VSYNC). DE = (hcnt<HWIDTH)&&(vcnt<VWIDTH).
- Disc state, per disc i: x_i, y_i as signed values of width clog2(HTOTAL)+2; dir_x_i and dir_y_i, where 0 = increasing.
- Reset state, per disc i:
  - x_i = RADIUS + ((HWIDTH-2*RADIUS-1)*i)/NBALLS
  - y_i = RADIUS + ((VWIDTH-2*RADIUS-1)*i)/NBALLS
  - dir_x_i = i[0], dir_y_i = 0
- Update strobe: one cycle, generated when hcnt==0 and vcnt==VWIDTH+VFPORCH. It acts only if en=1.
- X axis on each strobe, per disc (Y identical with VWIDTH):
  - dir 0: if x+STEP+RADIUS >= HWIDTH-1, then x <= HWIDTH-1-RADIUS and dir <= 1; else x <= x+STEP.
  - dir 1: if x-STEP <= RADIUS, then x <= RADIUS and dir <= 0; else x <= x-STEP.
- Pixel inside disc i: (hcnt-x_i)^2 + (vcnt-y_i)^2 <= RADIUS^2, computed signed with no truncation.
- Colour priority:
  - not DE: colour 0
  - border (hcnt==0, hcnt==HWIDTH-1, vcnt==0 or vcnt==VWIDTH-1): blue 24'h0050FF
  - lowest-index covering disc: palette[i]
  - otherwise black
- Palette, indices 0..7: 00FF00, FF0000, FFFF00, FF00FF, 00FFFF, FF8000, FFFFFF, 8080FF.
- Channel output: top CW bits of each 8-bit palette channel.
- Elaboration-time assertions: HWIDTH > 2*(RADIUS+STEP)+1; VWIDTH > 2*(RADIUS+STEP)+1; NBALLS in 1..8.

## Timing
- Pipeline stages:
  - stage 1 registers hcnt, vcnt and per-disc dx^2, dy^2
  - stage 2 registers the sum comparison, colour mux and sync/DE
- Latency: RGB, HS, VS, DE and frame_start all appear 2 cycles after the counter value that produced them and stay mutually aligned.
- Reset values of all outputs: RGB = 0, VGA_HS = ~HS_POL, VGA_VS = ~VS_POL, VGA_DE = 0, frame_start = 0.
- First frame_start: 2 cycles after the first rising edge following reset release.
- Disc update: takes effect 1 cycle after the strobe. It lies inside vertical blanking, so no visible frame tears.
- en sampling: en is sampled only on the strobe cycle. Toggling en mid-frame has no visible effect until the next strobe.
- Reset mid-frame: all state returns to reset values immediately (asynchronous assertion). Release is synchronous to clk.

## Test plan
Common bench parameters: HWIDTH=32, HFPORCH=2, HSYNC=4, HBPORCH=2 (HTOTAL=40); VWIDTH=24, VFPORCH=1, VSYNC=2, VBPORCH=1 (VTOTAL=28); RADIUS=3, STEP=2, CW=4.
- Reset hold, then release -> all outputs at reset values while rst_n=0; frame_start pulses every 1120 cycles; HS low for 4 of every 40 cycles; VS low for 80 cycles per frame; DE high for 32 cycles per line on 24 lines.
- NBALLS=1, en=1 -> x sequence per frame is 3,5,...,27, then 28 with dir flip, then 26,...,4, then 3 with flip. y sequence is 3,5,...,19, then 20 (flip), then 18.
- en=0 for 3 frames, then en=1 -> positions unchanged during the 3 frames; movement resumes on the first strobe after en rises.
- NBALLS=2, both discs forced overlapping via reset positions -> overlap pixels output palette[0] (R=0, G=F, B=0); border pixels output (0, 5, F); blanking outputs 0.
- Disc at x=3, y=3 -> pixel (3,6) is inside, pixel (3,7) is outside, pixel (0,3) shows border colour. Each colour appears 2 cycles after the matching counter value.
- Assert rst_n mid-line -> outputs return to reset values within the same cycle; disc positions return to their initial values.
